// File: rtl/clk_period_monitor_pkg.sv
// Shared definitions for the divided-clock period monitor.
package clk_period_monitor_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEAS = 2'd1,
        S_LOCK = 2'd2
    } state_e;

endpackage

// File: rtl/clk_period_monitor_sig_edge_sync.sv
// Two-flop synchronizer plus delay flop for edge detection of an asynchronous level.
module sig_edge_sync (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic rise,
    output logic fall,
    output logic level
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;
    assign level = s2_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures period and high time of a slow clock in clk_in cycles and declares lock
// once LOCK_COUNT consecutive periods fall within EXP_PERIOD +/- TOL.
module clk_period_monitor
    import clk_period_monitor_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 10,
    parameter int TOL        = 1,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 40
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             period_valid,
    output logic             locked,
    output logic             period_err,
    output logic             timeout
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int     LO_I  = (EXP_PERIOD > TOL) ? (EXP_PERIOD - TOL) : 0;
    localparam longint HI_L  = longint'(EXP_PERIOD) + longint'(TOL);
    localparam longint MAX_L = (longint'(1) << CNT_W) - longint'(1);
    localparam logic [CNT_W:0] LO_B = (CNT_W + 1)'(LO_I);
    localparam logic [CNT_W:0] HI_B = (CNT_W + 1)'((HI_L > MAX_L) ? MAX_L : HI_L);

    logic rise;
    logic fall;
    logic sync_level_unused;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MW-1:0]    match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             pv_q, pv_d;
    logic             locked_q, locked_d;
    logic             perr_q, perr_d;
    logic             to_q, to_d;
    logic             tol_ok;
    logic             cnt_hit;
    logic             lock_reached;

    sig_edge_sync u_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall),
        .level  (sync_level_unused)
    );

    // Widened by one bit so the clamped upper bound never wraps.
    function automatic logic in_tol(input logic [CNT_W-1:0] p);
        logic [CNT_W:0] pw;
        pw = {1'b0, p};
        return (pw >= LO_B) && (pw <= HI_B);
    endfunction

    assign tol_ok       = in_tol(cnt_q);
    assign cnt_hit      = (cnt_q == CNT_W'(TIMEOUT));
    assign lock_reached = (match_cnt_q >= MW'(LOCK_COUNT - 1));

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (rise) state_d = S_MEAS;
            S_MEAS: begin
                if (rise) begin
                    if (tol_ok && lock_reached) state_d = S_LOCK;
                end else if (cnt_hit) begin
                    state_d = S_IDLE;
                end
            end
            S_LOCK: begin
                if (rise) begin
                    if (!tol_ok) state_d = S_MEAS;
                end else if (cnt_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A rise in the same cycle as the timeout count takes priority.
    always_comb begin
        cnt_d       = rise ? CNT_W'(1) : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
        match_cnt_d = match_cnt_q;
        period_d    = period_q;
        high_d      = high_q;
        pv_d        = 1'b0;
        perr_d      = 1'b0;
        to_d        = 1'b0;
        locked_d    = locked_q;
        if (state_q != S_IDLE) begin
            if (rise) begin
                period_d = cnt_q;
                pv_d     = 1'b1;
                if (tol_ok) begin
                    if (!lock_reached) match_cnt_d = match_cnt_q + 1'b1;
                    else               locked_d    = 1'b1;
                end else begin
                    perr_d      = 1'b1;
                    match_cnt_d = '0;
                    locked_d    = 1'b0;
                end
            end else if (cnt_hit) begin
                to_d        = 1'b1;
                match_cnt_d = '0;
                locked_d    = 1'b0;
            end
            if (fall) high_d = cnt_q;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q       <= '0;
            match_cnt_q <= '0;
            period_q    <= '0;
            high_q      <= '0;
            pv_q        <= 1'b0;
            locked_q    <= 1'b0;
            perr_q      <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            match_cnt_q <= match_cnt_d;
            period_q    <= period_d;
            high_q      <= high_d;
            pv_q        <= pv_d;
            locked_q    <= locked_d;
            perr_q      <= perr_d;
            to_q        <= to_d;
        end
    end

    assign period_out   = period_q;
    assign high_out     = high_q;
    assign period_valid = pv_q;
    assign locked       = locked_q;
    assign period_err   = perr_q;
    assign timeout      = to_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Bench for clk_period_monitor: table-driven waveform rows, hand-written corner
// sequences and a randomized run, all checked against an event-level reference model.
module tb_clk_period_monitor;

    localparam int CNT_W = 16;
    localparam int EXP   = 10;
    localparam int TOL   = 1;
    localparam int LOCKN = 4;

    typedef struct {
        int h; int l; int n;
        int exp_p; int exp_h; bit exp_lock; int exp_v; int exp_e;
    } row_t;

    typedef struct {
        int p; int h; bit lk; bit er;
    } ev_t;

    logic             clk_in = 1'b0;
    logic             rst    = 1'b1;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             period_valid;
    logic             locked;
    logic             period_err;
    logic             timeout;

    clk_period_monitor dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .sig_in       (sig_in),
        .period_out   (period_out),
        .high_out     (high_out),
        .period_valid (period_valid),
        .locked       (locked),
        .period_err   (period_err),
        .timeout      (timeout)
    );

    always #5 clk_in = ~clk_in;

    int  n_checks = 0;
    int  n_fail   = 0;
    ev_t obs_q[$];
    ev_t exp_q[$];
    int  cyc = 0;
    int  last_pv_cyc = 0;
    int  to_cnt = 0;
    int  to_cyc = 0;

    // Reference model state: active = past the first rise, prev = last driven period.
    bit m_active = 1'b0;
    int m_match  = 0;
    bit m_locked = 1'b0;
    int m_prev_h = 0;
    int m_prev_l = 0;

    always @(negedge clk_in) begin
        cyc++;
        if (period_valid) begin
            obs_q.push_back('{int'(period_out), int'(high_out), locked, period_err});
            last_pv_cyc = cyc;
        end
        if (timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_rise(input int p, input int hh);
        bit ok;
        ok = (p - EXP <= TOL) && (EXP - p <= TOL);
        if (ok) begin
            m_match++;
            if (m_match >= LOCKN) m_locked = 1'b1;
        end else begin
            m_match  = 0;
            m_locked = 1'b0;
        end
        exp_q.push_back('{p, hh, m_locked, !ok});
    endtask

    task automatic model_idle();
        m_active = 1'b0;
        m_match  = 0;
        m_locked = 1'b0;
    endtask

    // Entered and left at posedge+1; one full sig_in period of h high, l low cycles.
    task automatic drive_period(input int h, input int l);
        if (m_active) model_rise(m_prev_h + m_prev_l, m_prev_h);
        m_active = 1'b1;
        m_prev_h = h;
        m_prev_l = l;
        sig_in = 1'b1;
        repeat (h) @(posedge clk_in);
        #1 sig_in = 1'b0;
        repeat (l) @(posedge clk_in);
        #1;
    endtask

    task automatic check_events(input string tag);
        check({tag, " event count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s ev%0d period", tag, i), obs_q[i].p, exp_q[i].p);
            check($sformatf("%s ev%0d high", tag, i), obs_q[i].h, exp_q[i].h);
            check($sformatf("%s ev%0d locked", tag, i), obs_q[i].lk, exp_q[i].lk);
            check($sformatf("%s ev%0d err", tag, i), obs_q[i].er, exp_q[i].er);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " period_out"}, period_out, 0);
        check({tag, " high_out"}, high_out, 0);
        check({tag, " period_valid"}, period_valid, 0);
        check({tag, " locked"}, locked, 0);
        check({tag, " period_err"}, period_err, 0);
        check({tag, " timeout"}, timeout, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        row_t rows[11];
        int   n_e;
        int   to0;
        int   p;
        int   h;

        rows[0]  = '{5, 5, 6, 10, 5, 1'b1, 5, 0};
        rows[1]  = '{7, 6, 1, 10, 7, 1'b1, 1, 0};
        rows[2]  = '{5, 5, 4, 10, 5, 1'b0, 4, 1};
        rows[3]  = '{5, 5, 1, 10, 5, 1'b1, 1, 0};
        rows[4]  = '{10, 10, 1, 10, 10, 1'b1, 1, 0};
        rows[5]  = '{6, 5, 1, 20, 6, 1'b0, 1, 1};
        rows[6]  = '{5, 4, 1, 11, 5, 1'b0, 1, 0};
        rows[7]  = '{6, 5, 1, 9, 6, 1'b0, 1, 0};
        rows[8]  = '{5, 4, 1, 11, 5, 1'b0, 1, 0};
        rows[9]  = '{3, 7, 1, 9, 3, 1'b1, 1, 0};
        rows[10] = '{3, 7, 4, 10, 3, 1'b1, 4, 0};

        repeat (3) @(posedge clk_in);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        for (int r = 0; r < 11; r++) begin
            for (int k = 0; k < rows[r].n; k++) drive_period(rows[r].h, rows[r].l);
            n_e = 0;
            foreach (obs_q[i]) if (obs_q[i].er) n_e++;
            check($sformatf("row%0d valids", r), obs_q.size(), rows[r].exp_v);
            check($sformatf("row%0d errs", r), n_e, rows[r].exp_e);
            check($sformatf("row%0d period_out", r), period_out, rows[r].exp_p);
            check($sformatf("row%0d high_out", r), high_out, rows[r].exp_h);
            check($sformatf("row%0d locked", r), locked, rows[r].exp_lock);
            check_events($sformatf("row%0d", r));
        end

        // sig_in stuck low while locked
        to0 = to_cnt;
        repeat (80) @(posedge clk_in);
        #1;
        check("timeout pulses", to_cnt - to0, 1);
        check("timeout delay after last valid", to_cyc - last_pv_cyc, 40);
        check("locked after timeout", locked, 0);
        check("no valids while stuck", obs_q.size(), 0);
        model_idle();

        // back from IDLE: first rise only arms the measurement
        drive_period(5, 5);
        check("valids after first rise from idle", obs_q.size(), 0);
        for (int k = 0; k < 5; k++) drive_period(5, 5);
        check("relock after timeout", locked, 1);
        check_events("post-timeout");

        // period equal to TIMEOUT: rise and timeout coincide, rise wins
        to0 = to_cnt;
        drive_period(20, 20);
        drive_period(5, 5);
        check("no timeout on coincident rise", to_cnt - to0, 0);
        check("period_out at coincident rise", period_out, 40);
        check_events("coincident");
        for (int k = 0; k < 4; k++) drive_period(5, 5);
        check("locked before reset", locked, 1);
        check_events("pre-reset");

        rst = 1'b1;
        @(posedge clk_in);
        #1 rst = 1'b0;
        check_all_zero("mid-lock reset");
        model_idle();

        drive_period(3, 7);
        check("valids after first rise post-reset", obs_q.size(), 0);
        for (int k = 0; k < 5; k++) drive_period(3, 7);
        check("post-reset valids", obs_q.size(), 5);
        check("duty period_out", period_out, 10);
        check("duty high_out", high_out, 3);
        check("duty locked", locked, 1);
        check_events("post-reset");

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) p = int'($urandom_range(3, 30));
            else                           p = int'($urandom_range(8, 12));
            h = int'($urandom_range(1, p - 1));
            drive_period(h, p - h);
        end
        repeat (4) @(posedge clk_in);
        #1;
        m_prev_l += 4;
        check("random locked", locked, m_locked);
        check("random timeouts", timeout, 0);
        check_events("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
